if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
//   Parametrised instruction-fetch stage with prefetch queue. Issues sequential fetch requests to the
//   ICache over a valid/ready channel, accepts in-order responses of variable latency, and buffers
//   {PC, instruction} pairs in a QDEPTH-entry FIFO feeding ID. Redirects (branch mispredict or taken
//   branch) flush the queue and discard stale in-flight responses. Sits between the PC source and IF/ID.
// PARAMETERS
//   XLEN      32   address/instruction width
//   QDEPTH    4    prefetch queue entries (power of 2, >=2); also caps in-flight requests
//   RESET_PC  0    FetchPc value after reset
// PORTS
//   clk          in   1     clock, rising edge
//   rst          in   1     reset, asynchronous, active-low
//   Enable       in   1     1 = request issue permitted; 0 = no new requests (in-flight still completes)
//   ReqValid     out  1     fetch request valid
//   ReqReady     in   1     ICache accepts request
//   ReqAddr      out  XLEN  fetch address (= FetchPc)
//   RspValid     in   1     ICache response valid (in request order, always accepted)
//   RspInst      in   XLEN  instruction for oldest in-flight request
//   Redirect     in   1     flush + restart fetch (PredictFail or taken branch)
//   RedirectPc   in   XLEN  new fetch PC
//   OutValid     out  1     queue head valid toward ID
//   OutReady     in   1     ID accepts head (IF_ID_Write)
//   OutPc        out  XLEN  PC of head entry
//   OutInst      out  XLEN  instruction of head entry
//   QueueCount   out  clog2(QDEPTH+1)  entries held
//   MisalignErr  out  1     1-cycle pulse: Redirect with RedirectPc[1:0]!=0
// BEHAVIOUR
//   Reset (async, rst=0): FetchPc=RESET_PC, ExpectPc=RESET_PC, queue empty, InFlight=0, DropCnt=0;
//     ReqValid=0, OutValid=0, QueueCount=0, MisalignErr=0; ReqAddr=RESET_PC; OutPc/OutInst=0.
//     Reset mid-transaction drops all state; late responses after reset are outside contract.
//   Credit: ReqValid = Enable & !Redirect & (QueueCount + InFlight < QDEPTH). Guarantees every
//     non-dropped response finds a free slot; no response back-pressure exists.
//   Request: ReqValid&ReqReady -> FetchPc += 4, InFlight += 1. ReqAddr/ReqValid stable while unaccepted.
//   Response: RspValid -> InFlight -= 1. If DropCnt>0: discard, DropCnt -= 1. Else push
//     {ExpectPc, RspInst}, ExpectPc += 4. Issue + response same cycle: InFlight unchanged.
//   Output: OutValid = (QueueCount!=0) & !Redirect; head popped on OutValid&OutReady. Push and pop
//     same cycle: count unchanged (legal when full). Response is visible at OutValid next cycle (1-cycle latency).
//   Redirect (highest priority, single cycle):
//     - queue cleared (pop ignored), FetchPc<=RedirectPc, ExpectPc<=RedirectPc, no request issued
//     - DropCnt <= InFlight - RspValid (outstanding after this cycle; same-cycle response discarded)
//     - InFlight <= InFlight - RspValid
//     - MisalignErr pulses next cycle if RedirectPc[1:0]!=0; PC still loaded with [1:0] forced to 0.
//     Back-to-back Redirects: last wins; DropCnt recomputed each time from InFlight.
//   Arithmetic: PC increments modulo 2^XLEN (wrap 0xFFFFFFFC -> 0x0, no flag). Counters never
//     exceed QDEPTH by credit rule; underflow on unexpected RspValid with InFlight=0 is a protocol error.
//   Enable=0: issue stops; in-flight responses still drained/queued; Redirect still applies.
// TESTING
//   1 Reset, Enable=1, ReqReady=1, 1-cycle rsp latency -> ReqAddr 0,4,8,...; OutPc 0,4,8 with matching RspInst.
//   2 OutReady=0, QDEPTH=4 -> exactly 4 requests accepted total, ReqValid=0, QueueCount=4; OutReady=1 resumes.
//   3 3-cycle rsp latency, 2 in flight, Redirect to 0x100 -> both late rsps dropped, next OutPc=0x100.
//   4 Redirect same cycle as RspValid and OutValid&OutReady -> rsp discarded, no pop counted, QueueCount=0 next.
//   5 Redirect RedirectPc=0x102 -> MisalignErr 1 cycle, ReqAddr=0x100.
//   6 Redirect to 0xFFFFFFF8 -> ReqAddr 0xFFFFFFF8, 0xFFFFFFFC, 0x0; assert rst mid-fetch -> all outputs reset immediately.

Source files
------------

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: issues sequential ICache requests under a credit limit and
// buffers in-order {PC, instruction} responses in a small FIFO toward decode.
module if_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Enable,
    output logic                        ReqValid,
    input  logic                        ReqReady,
    output logic [XLEN-1:0]             ReqAddr,
    input  logic                        RspValid,
    input  logic [XLEN-1:0]             RspInst,
    input  logic                        Redirect,
    input  logic [XLEN-1:0]             RedirectPc,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [XLEN-1:0]             OutPc,
    output logic [XLEN-1:0]             OutInst,
    output logic [$clog2(QDEPTH+1)-1:0] QueueCount,
    output logic                        MisalignErr
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] expect_pc;
    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic [XLEN-1:0] q_inst [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   drop_cnt;
    logic            misalign_err;

    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            rsp_push;
    logic            pop;
    logic [XLEN-1:0] redirect_base;

    // Queue slots plus outstanding requests never exceed QDEPTH, so every kept response has room.
    assign occupancy     = {1'b0, count} + {1'b0, in_flight};
    assign ReqValid      = rst & Enable & ~Redirect & (occupancy < (CW+1)'(QDEPTH));
    assign ReqAddr       = fetch_pc;
    assign req_fire      = ReqValid & ReqReady;
    assign rsp_push      = RspValid & (drop_cnt == '0) & ~Redirect;
    assign OutValid      = (count != '0) & ~Redirect;
    assign pop           = OutValid & OutReady;
    assign redirect_base = {RedirectPc[XLEN-1:2], 2'b00};

    assign OutPc         = (count != '0) ? q_pc[rd_ptr]   : '0;
    assign OutInst       = (count != '0) ? q_inst[rd_ptr] : '0;
    assign QueueCount    = count;
    assign MisalignErr   = misalign_err;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc     <= RESET_PC;
            expect_pc    <= RESET_PC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            in_flight    <= '0;
            drop_cnt     <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= Redirect & (RedirectPc[1:0] != 2'b00);
            if (Redirect) begin
                // Everything still outstanding after this edge belongs to the old stream.
                fetch_pc  <= redirect_base;
                expect_pc <= redirect_base;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                in_flight <= in_flight - CW'(RspValid);
                drop_cnt  <= in_flight - CW'(RspValid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                in_flight <= in_flight + CW'(req_fire) - CW'(RspValid);
                if (RspValid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (rsp_push) begin
                    expect_pc <= expect_pc + XLEN'(4);
                    wr_ptr    <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(rsp_push) - CW'(pop);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            q_pc[wr_ptr]   <= expect_pc;
            q_inst[wr_ptr] <= RspInst;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: an in-order ICache model with configurable
// latency, a scoreboard of expected {PC, instruction} pairs, phase vectors and corner sequences.
module tb_if_prefetch_unit;

    localparam int XLEN   = 32;
    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            Enable, ReqValid, ReqReady, RspValid, Redirect;
    logic            OutValid, OutReady, MisalignErr;
    logic [XLEN-1:0] ReqAddr, RspInst, RedirectPc, OutPc, OutInst;
    logic [CW-1:0]   QueueCount;

    if_prefetch_unit #(.XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .Enable(Enable), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqAddr(ReqAddr), .RspValid(RspValid), .RspInst(RspInst), .Redirect(Redirect),
        .RedirectPc(RedirectPc), .OutValid(OutValid), .OutReady(OutReady), .OutPc(OutPc),
        .OutInst(OutInst), .QueueCount(QueueCount), .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] inst; int due; } rsp_t;
    typedef struct {
        logic        enable;
        logic        req_ready;
        logic        out_ready;
        int          ncyc;
        int          exp_fires;
        logic [31:0] exp_count;
        logic        exp_req_valid;
    } vec_t;

    exp_t        sb[$];
    rsp_t        icq[$];
    vec_t        vecs[4];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          fires  = 0;
    logic [31:0] model_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge with the caller's inputs applied.
    task automatic tick();
        exp_t e;
        if (icq.size() != 0 && icq[0].due <= cyc) begin
            RspValid = 1'b1;
            RspInst  = icq[0].inst;
        end else begin
            RspValid = 1'b0;
            RspInst  = '0;
        end
        #1;
        if (OutValid && OutReady) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got pc 0x%08h expected no output", OutPc);
            end else begin
                e = sb.pop_front();
                check("out_pc", OutPc, e.pc);
                check("out_inst", OutInst, e.inst);
            end
        end
        if (RspValid) icq.delete(0);
        if (Redirect) begin
            sb.delete();
            model_pc = RedirectPc & ~32'h3;
        end
        if (ReqValid && ReqReady) begin
            fires++;
            check("req_addr", ReqAddr, model_pc);
            icq.push_back('{inst: inst_of(ReqAddr), due: cyc + lat});
            sb.push_back('{pc: model_pc, inst: inst_of(model_pc)});
            model_pc += 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(ReqValid), 32'd0);
        check({tag, "_out_valid"}, 32'(OutValid), 32'd0);
        check({tag, "_count"}, 32'(QueueCount), 32'd0);
        check({tag, "_req_addr"}, ReqAddr, 32'd0);
        check({tag, "_out_pc"}, OutPc, 32'd0);
        check({tag, "_out_inst"}, OutInst, 32'd0);
        check({tag, "_misalign"}, 32'(MisalignErr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        // enable, req_ready, out_ready, cycles, fires, count, req_valid
        vecs[0] = '{1'b1, 1'b1, 1'b1, 20, 20, 32'd1, 1'b1};  // streaming, 1-cycle latency
        vecs[1] = '{1'b1, 1'b1, 1'b0, 12,  2, 32'd4, 1'b0};  // decode stalls: credit fills queue
        vecs[2] = '{1'b1, 1'b1, 1'b1, 10,  9, 32'd2, 1'b1};  // stall released
        vecs[3] = '{1'b0, 1'b1, 1'b1,  6,  0, 32'd0, 1'b0};  // issue disabled: drain

        rst = 1'b0; Enable = 1'b1; ReqReady = 1'b1; RspValid = 1'b0; RspInst = '0;
        Redirect = 1'b0; RedirectPc = '0; OutReady = 1'b1;
        model_pc = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        foreach (vecs[i]) begin
            Enable   = vecs[i].enable;
            ReqReady = vecs[i].req_ready;
            OutReady = vecs[i].out_ready;
            fires    = 0;
            repeat (vecs[i].ncyc) tick();
            check($sformatf("vec%0d_fires", i), 32'(fires), 32'(vecs[i].exp_fires));
            check($sformatf("vec%0d_count", i), 32'(QueueCount), vecs[i].exp_count);
            check($sformatf("vec%0d_req_valid", i), 32'(ReqValid), 32'(vecs[i].exp_req_valid));
        end

        // Redirect with two slow responses outstanding: both must be dropped.
        lat = 3; Enable = 1'b1; OutReady = 1'b1;
        tick();
        tick();
        check("t3_in_flight_rsp", 32'(icq.size()), 32'd2);
        Redirect = 1'b1; RedirectPc = 32'h100;
        tick();
        Redirect = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (OutValid) break;
            tick();
        end
        check("t3_out_valid", 32'(OutValid), 32'd1);
        check("t3_first_pc", OutPc, 32'h100);
        check("t3_first_inst", OutInst, inst_of(32'h100));
        lat = 1; Enable = 1'b0;
        repeat (8) tick();
        check("t3_drained", 32'(QueueCount), 32'd0);

        // Redirect coinciding with a response and a would-be pop.
        Enable = 1'b1;
        repeat (5) tick();
        check("t4_count_before", 32'(QueueCount), 32'd1);
        Redirect = 1'b1; RedirectPc = 32'h200;
        #1;
        check("t4_out_valid_gated", 32'(OutValid), 32'd0);
        check("t4_req_valid_gated", 32'(ReqValid), 32'd0);
        tick();
        Redirect = 1'b0;
        check("t4_count_after", 32'(QueueCount), 32'd0);
        check("t4_misalign", 32'(MisalignErr), 32'd0);
        repeat (6) tick();

        // Misaligned redirect target.
        Redirect = 1'b1; RedirectPc = 32'h102;
        tick();
        Redirect = 1'b0; Enable = 1'b0;
        check("t5_misalign_pulse", 32'(MisalignErr), 32'd1);
        check("t5_req_addr", ReqAddr, 32'h100);
        tick();
        check("t5_misalign_clear", 32'(MisalignErr), 32'd0);
        repeat (4) tick();

        // PC wrap at the top of the address space, then reset mid-fetch.
        Enable = 1'b1; Redirect = 1'b1; RedirectPc = 32'hFFFF_FFF8;
        tick();
        Redirect = 1'b0;
        check("t6_addr0", ReqAddr, 32'hFFFF_FFF8);
        tick();
        check("t6_addr1", ReqAddr, 32'hFFFF_FFFC);
        tick();
        check("t6_addr2", ReqAddr, 32'h0000_0000);
        OutReady = 1'b0;
        tick();
        tick();
        check("t6_queue_busy", 32'(QueueCount != '0), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async_rst");
        sb.delete();
        icq.delete();
        model_pc = 32'd0;
        @(negedge clk);
        rst = 1'b1; Enable = 1'b0; OutReady = 1'b1;
        repeat (3) tick();
        check("end_count", 32'(QueueCount), 32'd0);
        check("end_req_addr", ReqAddr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
